pc_source_unit: RTL and testbench
=================================

Name: pc_source_unit

Overview:
- Parametrised next-PC selection and PC-register block for the multicycle datapath.
- Selects one of NUM_SOURCES candidate addresses and registers it as the PC under write / conditional-write control.
- Unlike the plain combinational PC mux, it defines behaviour for out-of-range selectors and detects misaligned targets.
- On either fault it runs a two-cycle exception sequence: saves EPC, then redirects the PC to a fixed vector.

Parameters:
- DATA_WIDTH, 32, width of the PC and of every candidate address.
- NUM_SOURCES, 5, number of candidate next-PC inputs (minimum 2).
- SEL_WIDTH, $clog2(NUM_SOURCES), selector width; derived localparam, not overridable.
- RESET_PC, 0, PC value after reset.
- EXC_VECTOR, 32'h0000_00FC, PC loaded on exception entry; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  SEL_WIDTH  candidate index.
- data_in  in  NUM_SOURCES*DATA_WIDTH  flattened candidates; slot i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- pc_write  in  1  unconditional PC update request.
- pc_write_cond  in  1  conditional update request (branch).
- branch_taken  in  1  qualifies pc_write_cond.
- pc_out  out  DATA_WIDTH  current PC.
- epc_out  out  DATA_WIDTH  PC saved at the last exception.
- exc_valid  out  1  one-cycle pulse on exception entry.
- exc_cause  out  2  00 none, 01 invalid selector, 10 misaligned target; held until the next exception.
- stall  out  1  high while the exception sequence runs.

Behaviour:
- Reset (async assert, sync deassert at the integration level):
  - pc_out = RESET_PC; epc_out = 0; exc_valid = 0; exc_cause = 00; stall = 0; state = RUN.
- Update request: upd = pc_write | (pc_write_cond & branch_taken).
- Target: tgt = slot[sel] when sel < NUM_SOURCES; otherwise tgt is don't-care. The datapath must never produce a latch or X on sel out of range.
- Fault checks, evaluated only when upd = 1 in RUN:
  - bad_sel = (sel >= NUM_SOURCES).
  - misal = (tgt[1:0] != 0), evaluated only when bad_sel = 0.
- State RUN:
  - upd & no fault: pc_out <= tgt at the next rising edge (1-cycle latency); stay in RUN.
  - upd & fault: go to EXC_SAVE.
    - epc_out <= pc_out (the PC of the faulting update, not tgt).
    - exc_cause <= 01 if bad_sel, else 10.
    - exc_valid <= 1.
    - pc_out unchanged.
  - No upd: all registers hold.
- State EXC_SAVE (1 cycle):
  - stall = 1; exc_valid = 1 in this cycle only.
  - pc_out <= EXC_VECTOR; next state EXC_DONE.
- State EXC_DONE (1 cycle):
  - stall = 1; exc_valid = 0; next state RUN.
- Requests during EXC_SAVE or EXC_DONE are ignored and not queued; the controller must hold the instruction while stall = 1.
- stall and exc_valid are registered, decoded directly from state flops.
- pc_write and pc_write_cond both high: treated as a single update (OR); no double effect.
- pc_write_cond high with branch_taken low: no update and no fault check, even if sel is invalid.
- Reset asserted mid-sequence: immediate return to reset values; the partial exception is discarded.
- exc_cause is sticky: it is not cleared on return to RUN.
- Width rules: no arithmetic inside the block; pc_out is exactly the selected slot or a constant.

Decomposition:
- Shared package (cpu_pkg): exc_cause encodings (EXC_NONE, EXC_BAD_SEL, EXC_MISALIGN) and the state enum (RUN, EXC_SAVE, EXC_DONE).
- Sub-module pc_cand_select: purely combinational N-way indexed selector.
  - Outputs tgt and bad_sel.
  - Fully specified default (zero) for out-of-range indices.
  - Reusable for the other datapath muxes.
- Top level owns the FSM, PC register and EPC register.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, release -> pc_out = 0, epc_out = 0, stall = 0, exc_cause = 00.
- Plain write: slot2 = 0x0000_0040, sel = 2, pc_write = 1 for 1 cycle -> pc_out = 0x40 one edge later; no exc_valid.
- Conditional branch:
  - pc_write_cond = 1, branch_taken = 0, slot1 = 0x80, sel = 1 -> pc_out unchanged.
  - Repeat with branch_taken = 1 -> pc_out = 0x80.
- Misaligned target: pc_out = 0x40, slot3 = 0x0000_0102, sel = 3, pc_write -> epc_out = 0x40, exc_cause = 10, exc_valid one cycle, stall 2 cycles, then pc_out = 0xFC.
- Invalid selector with NUM_SOURCES = 5: sel = 6, pc_write -> exc_cause = 01, epc = prior PC, pc_out = 0xFC.
  - Also drive pc_write during stall -> request ignored; pc_out stays 0xFC.
- Reset mid-exception: assert reset_n = 0 in EXC_SAVE -> pc_out = 0, stall = 0, epc_out = 0 immediately (async).

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================
// cpu_pkg : shared exception-cause encodings and PC FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_BAD_SEL  = 2'b01,
    EXC_MISALIGN = 2'b10
  } exc_cause_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    EXC_SAVE = 2'b01,
    EXC_DONE = 2'b10
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_cand_select.sv
// ============================================================
// pc_cand_select : combinational N-way indexed selector, zero default
// Rev 1.0
// ============================================================
`default_nettype none

module pc_cand_select #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SOURCES = 5,
  parameter int SEL_WIDTH   = 3
) (
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]             tgt,
  output logic                              bad_sel
);

  // Loop compare keeps the range check correct even when NUM_SOURCES is a
  // power of two and every selector code is legal.
  always_comb begin
    tgt     = '0;
    bad_sel = 1'b1;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        tgt     = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        bad_sel = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_source_unit.sv
// ============================================================
// pc_source_unit : next-PC select, PC/EPC registers, fault sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module pc_source_unit
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_SOURCES = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR  = 32'h0000_00FC
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [$clog2(NUM_SOURCES)-1:0]     sel,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0]  data_in,
  input  logic                               pc_write,
  input  logic                               pc_write_cond,
  input  logic                               branch_taken,
  output logic [DATA_WIDTH-1:0]              pc_out,
  output logic [DATA_WIDTH-1:0]              epc_out,
  output logic                               exc_valid,
  output logic [1:0]                         exc_cause,
  output logic                               stall
);

  localparam int SEL_WIDTH = $clog2(NUM_SOURCES);

  logic [DATA_WIDTH-1:0] tgt;
  logic                  bad_sel;
  logic                  upd;
  logic                  misal;
  pc_state_e             state;

  pc_cand_select #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_SOURCES (NUM_SOURCES),
    .SEL_WIDTH   (SEL_WIDTH)
  ) u_sel (
    .sel     (sel),
    .data_in (data_in),
    .tgt     (tgt),
    .bad_sel (bad_sel)
  );

  assign upd   = pc_write | (pc_write_cond & branch_taken);
  assign misal = (tgt[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      pc_out    <= RESET_PC;
      epc_out   <= '0;
      exc_cause <= EXC_NONE;
    end else begin
      case (state)
        RUN: begin
          if (upd) begin
            if (bad_sel || misal) begin
              // EPC records the PC of the faulting instruction, not its target
              epc_out   <= pc_out;
              exc_cause <= bad_sel ? EXC_BAD_SEL : EXC_MISALIGN;
              state     <= EXC_SAVE;
            end else begin
              pc_out <= tgt;
            end
          end
        end
        EXC_SAVE: begin
          pc_out <= EXC_VECTOR;
          state  <= EXC_DONE;
        end
        EXC_DONE: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  assign stall     = (state != RUN);
  assign exc_valid = (state == EXC_SAVE);

endmodule

`default_nettype wire

// File: tb/tb_pc_source_unit.sv
// ============================================================
// tb_pc_source_unit : directed + randomized checks against a PC model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pc_source_unit;

  localparam int DW = 32;
  localparam int NS = 5;
  localparam logic [31:0] VEC = 32'h0000_00FC;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    sel = '0;
  logic [NS*DW-1:0] data_in = '0;
  logic          pc_write = 1'b0;
  logic          pc_write_cond = 1'b0;
  logic          branch_taken = 1'b0;
  logic [DW-1:0] pc_out, epc_out;
  logic          exc_valid, stall;
  logic [1:0]    exc_cause;

  int tests = 0;
  int fails = 0;

  // Reference model: PC, EPC, sticky cause and cycles of stall left.
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  int          m_left;

  pc_source_unit #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .RESET_PC(32'h0), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .data_in(data_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
    .pc_out(pc_out), .epc_out(epc_out), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_left = 0;
  endtask

  task automatic set_slot(input int idx, input logic [31:0] v);
    data_in[idx*DW +: DW] = v;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] t;
    int s;
    s = int'(sel);
    if (m_left == 2) begin
      m_pc = VEC; m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (pc_write || (pc_write_cond && branch_taken)) begin
      t = (s < NS) ? data_in[s*DW +: DW] : 32'h0;
      if (s >= NS) begin
        m_epc = m_pc; m_cause = 2'b01; m_left = 2;
      end else if (t % 4 != 0) begin
        m_epc = m_pc; m_cause = 2'b10; m_left = 2;
      end else begin
        m_pc = t;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1;
    @(negedge clk);
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", pc_out); end
    tests++; if (epc_out !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", epc_out); end
    tests++; if (stall !== 1'b0 || exc_valid !== 1'b0) begin fails++; $display("FAIL reset_flags stall %b valid %b exp 0 0", stall, exc_valid); end
    tests++; if (exc_cause !== 2'b00) begin fails++; $display("FAIL reset_cause got %b exp 00", exc_cause); end
    @(posedge clk); #1;
  endtask

  task automatic test_plain_write();
    set_slot(2, 32'h40); sel = 2; pc_write = 1;
    tick();
    pc_write = 0;
    tests++; if (pc_out !== 32'h40) begin fails++; $display("FAIL plain_write pc got %h exp 00000040", pc_out); end
    tests++; if (exc_valid !== 1'b0) begin fails++; $display("FAIL plain_write exc_valid got %b exp 0", exc_valid); end
  endtask

  task automatic test_cond_branch();
    set_slot(1, 32'h80); sel = 1; pc_write_cond = 1; branch_taken = 0;
    tick();
    tests++; if (pc_out !== 32'h40) begin fails++; $display("FAIL cond_not_taken pc got %h exp 00000040", pc_out); end
    sel = 6;  // invalid selector must not fault when the branch is not taken
    tick();
    tests++; if (stall !== 1'b0 || pc_out !== 32'h40) begin fails++; $display("FAIL cond_bad_sel_ignored stall %b pc %h exp 0 00000040", stall, pc_out); end
    sel = 1; branch_taken = 1;
    tick();
    tests++; if (pc_out !== 32'h80) begin fails++; $display("FAIL cond_taken pc got %h exp 00000080", pc_out); end
    // both requests at once behave as one update
    sel = 2; pc_write = 1;
    tick();
    idle_inputs();
    tests++; if (pc_out !== 32'h40 || stall !== 1'b0) begin fails++; $display("FAIL both_writes pc %h stall %b exp 00000040 0", pc_out, stall); end
  endtask

  task automatic test_misaligned();
    set_slot(3, 32'h102); sel = 3; pc_write = 1;
    tick();
    pc_write = 0;
    tests++; if (exc_valid !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL misal_entry valid %b stall %b exp 1 1", exc_valid, stall); end
    tests++; if (epc_out !== 32'h40) begin fails++; $display("FAIL misal_epc got %h exp 00000040", epc_out); end
    tests++; if (exc_cause !== 2'b10) begin fails++; $display("FAIL misal_cause got %b exp 10", exc_cause); end
    tests++; if (pc_out !== 32'h40) begin fails++; $display("FAIL misal_pc_hold got %h exp 00000040", pc_out); end
    tick();
    tests++; if (exc_valid !== 1'b0 || stall !== 1'b1 || pc_out !== VEC) begin fails++; $display("FAIL misal_done valid %b stall %b pc %h exp 0 1 %h", exc_valid, stall, pc_out, VEC); end
    tick();
    tests++; if (stall !== 1'b0 || pc_out !== VEC || exc_cause !== 2'b10) begin fails++; $display("FAIL misal_return stall %b pc %h cause %b exp 0 %h 10", stall, pc_out, exc_cause, VEC); end
  endtask

  task automatic test_bad_sel();
    sel = 6; pc_write = 1;
    tick();
    tests++; if (exc_cause !== 2'b01 || exc_valid !== 1'b1) begin fails++; $display("FAIL badsel_entry cause %b valid %b exp 01 1", exc_cause, exc_valid); end
    tests++; if (epc_out !== VEC) begin fails++; $display("FAIL badsel_epc got %h exp %h", epc_out, VEC); end
    sel = 2;  // valid write held during stall must be dropped
    tick();
    tick();
    tests++; if (pc_out !== VEC || stall !== 1'b0) begin fails++; $display("FAIL badsel_ignore pc %h stall %b exp %h 0", pc_out, stall, VEC); end
    pc_write = 0;
    tick();
    tests++; if (pc_out !== VEC) begin fails++; $display("FAIL badsel_no_queue pc got %h exp %h", pc_out, VEC); end
  endtask

  task automatic test_reset_mid_exc();
    sel = 7; pc_write = 1;
    tick();
    idle_inputs();
    tests++; if (exc_valid !== 1'b1) begin fails++; $display("FAIL midrst_setup valid got %b exp 1", exc_valid); end
    reset_n = 0;
    #1;
    model_reset();
    tests++; if (pc_out !== 32'h0 || stall !== 1'b0 || epc_out !== 32'h0 || exc_valid !== 1'b0) begin
      fails++; $display("FAIL midrst pc %h stall %b epc %h valid %b exp 0 0 0 0", pc_out, stall, epc_out, exc_valid);
    end
    tests++; if (exc_cause !== 2'b00) begin fails++; $display("FAIL midrst_cause got %b exp 00", exc_cause); end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        set_slot(i, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      sel           = 3'($urandom_range(0, 7));
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = $urandom_range(0, 1) == 1;
      branch_taken  = $urandom_range(0, 1) == 1;
      tick();
      tests++;
      if (pc_out !== m_pc || epc_out !== m_epc || exc_cause !== m_cause ||
          stall !== (m_left > 0) || exc_valid !== (m_left == 2)) begin
        fails++;
        $display("FAIL random[%0d] pc %h/%h epc %h/%h cause %b/%b stall %b/%b valid %b/%b (got/exp)",
                 n, pc_out, m_pc, epc_out, m_epc, exc_cause, m_cause,
                 stall, (m_left > 0), exc_valid, (m_left == 2));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_plain_write();
    test_cond_branch();
    test_misaligned();
    test_bad_sel();
    test_reset_mid_exc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
